// File: rtl/shape_frame_pkg.sv
// rtl/shape_frame_pkg.sv - shared frame layout for the shape-register UART command link
//
// Holds the frame geometry, field widths, the byte-serializer state encoding
// and the pack/unpack helpers. Transmitter and receiver both import this
// package so the two ends of the link agree on the bit layout.
package shape_frame_pkg;

  localparam int FRAME_BYTES  = 5;
  localparam int FRAME_BITS   = 40;
  localparam int SHAPE_ADDR_W = 11;
  localparam int REG_ADDR_W   = 12;
  localparam int DATA_W       = 12;

  // Index of the final byte of a frame, sized to the 3-bit byte counter.
  localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);

  // Line state of the single-byte serializer.
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // One decoded shape-register write command.
  typedef struct packed {
    logic                    prog;
    logic [SHAPE_ADDR_W-1:0] shape_addr;
    logic [REG_ADDR_W-1:0]   reg_addr;
    logic [DATA_W-1:0]       data;
  } shape_cmd_t;

  // Frame word: four zero pad bits above the program flag, then the fields
  // from most to least significant. Byte 0 on the wire is bits [39:32].
  function automatic logic [FRAME_BITS-1:0] pack_frame(
    input logic                    prog,
    input logic [SHAPE_ADDR_W-1:0] shape_addr,
    input logic [REG_ADDR_W-1:0]   reg_addr,
    input logic [DATA_W-1:0]       data
  );
    return {4'b0000, prog, shape_addr, reg_addr, data};
  endfunction

  // Receiver-side inverse of pack_frame; the pad nibble is discarded.
  function automatic shape_cmd_t unpack_frame(input logic [FRAME_BITS-1:0] frame);
    shape_cmd_t cmd;
    cmd.prog       = frame[35];
    cmd.shape_addr = frame[34:24];
    cmd.reg_addr   = frame[23:12];
    cmd.data       = frame[11:0];
    return cmd;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 serializer for one byte with back-to-back restart
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   start         load byte_data and begin a start bit; honoured in IDLE and
//                 on the final cycle of a stop bit (gapless chaining)
//   byte_data     byte to send, sampled on the edge where start is taken
//   tx            registered UART line, idle high
//   byte_done     high during the last cycle of the stop bit
//   state         current line state
module uart_tx_byte
  import shape_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_data,
  output logic       tx,
  output logic       byte_done,
  output tx_state_e  state
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic              bit_end;

  assign bit_end   = (baud_cnt == BAUD_LAST);
  // Combinational so the owner can chain the next byte on this same edge.
  assign byte_done = (state == TX_STOP) && bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (start) begin
            state <= TX_START;
            shreg <= byte_data;
            tx    <= 1'b0;
          end
        end

        TX_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= TX_DATA;
            tx       <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        TX_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              state   <= TX_STOP;
              tx      <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              // shreg[0] is always the bit on the line; shift the next one in.
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        TX_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (start) begin
              state <= TX_START;
              shreg <= byte_data;
              tx    <= 1'b0;
            end else begin
              state <= TX_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state    <= TX_IDLE;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          tx       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/shape_frame_tx.sv
// rtl/shape_frame_tx.sv - serializes one shape-register write into a 5-byte UART frame
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   cmd_valid       command present on the *_in fields
//   cmd_ready       block is idle and will accept on this edge
//   program_in      program flag
//   shape_addr_in   shape address (11 bits)
//   reg_addr_in     register address (12 bits)
//   data_in         register data (12 bits)
//   serial_output   8N1 UART line, idle high, MSB byte first, LSB bit first
//   busy            frame in progress
//   frame_done      one-cycle pulse as the last stop bit completes
module shape_frame_tx
  import shape_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    program_in,
  input  logic [SHAPE_ADDR_W-1:0] shape_addr_in,
  input  logic [REG_ADDR_W-1:0]   reg_addr_in,
  input  logic [DATA_W-1:0]       data_in,
  output logic                    serial_output,
  output logic                    busy,
  output logic                    frame_done
);

  tx_state_e             tx_state;
  logic [FRAME_BITS-1:0] frame_reg;
  logic [FRAME_BITS-1:0] frame_in;
  logic [2:0]            byte_cnt;
  logic                  accept;
  logic                  byte_done;
  logic                  byte_start;
  logic [7:0]            byte_data;

  assign frame_in  = pack_frame(program_in, shape_addr_in, reg_addr_in, data_in);
  assign cmd_ready = (tx_state == TX_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // The first byte comes straight from the inputs so the start bit begins on
  // the accept edge. Later bytes are chained at the end of each stop bit; at
  // that point frame_reg[39:32] still holds the byte just sent, so the next
  // one sits directly below it.
  assign byte_start = accept || (byte_done && (byte_cnt != LAST_BYTE));
  assign byte_data  = accept ? frame_in[FRAME_BITS-1 -: 8]
                             : frame_reg[FRAME_BITS-9 -: 8];

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk       (clk),
    .rst       (rst),
    .start     (byte_start),
    .byte_data (byte_data),
    .tx        (serial_output),
    .byte_done (byte_done),
    .state     (tx_state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_reg  <= '0;
      byte_cnt   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (accept) begin
        frame_reg <= frame_in;
        byte_cnt  <= '0;
        busy      <= 1'b1;
      end else if (byte_done) begin
        if (byte_cnt == LAST_BYTE) begin
          byte_cnt   <= '0;
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end else begin
          byte_cnt  <= byte_cnt + 1'b1;
          frame_reg <= {frame_reg[FRAME_BITS-9:0], 8'h00};
        end
      end
    end
  end

endmodule

// File: tb/tb_shape_frame_tx.sv
// tb/tb_shape_frame_tx.sv - self-checking scoreboard bench for shape_frame_tx
module tb_shape_frame_tx;

  localparam int C = 4;

  typedef struct {
    logic [7:0] b;
    int         c;
  } exp_byte_t;

  typedef struct {
    logic        prog;
    logic [10:0] shape;
    logic [11:0] regad;
    logic [11:0] data;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        program_in = 1'b0;
  logic [10:0] shape_addr_in = '0;
  logic [11:0] reg_addr_in = '0;
  logic [11:0] data_in = '0;
  logic        serial_output;
  logic        busy;
  logic        frame_done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int last_acc = 0;
  int last_done = 0;
  logic prev_fd = 1'b0;

  exp_byte_t exp_q[$];
  cmd_t      cmd_q[$];
  logic [39:0] rx_word = '0;
  int          rx_n = 0;

  shape_frame_tx #(.CLKS_PER_BIT(C)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .program_in    (program_in),
    .shape_addr_in (shape_addr_in),
    .reg_addr_in   (reg_addr_in),
    .data_in       (data_in),
    .serial_output (serial_output),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Frame completion and acceptance, in one block so both see a consistent
  // last_acc when a held command is taken right after frame_done.
  always @(negedge clk) begin
    if (frame_done) begin
      done_cnt++;
      last_done = cyc;
      check("done_lat", 64'(cyc - last_acc), 64'(50 * C));
      check("done_busy", 64'(busy), 64'd0);
      check("done_ready", 64'(cmd_ready), 64'd1);
      check("done_width", 64'(prev_fd), 64'd0);
    end
    prev_fd = frame_done;
    if (!rst && cmd_valid && cmd_ready) begin
      logic [39:0] w;
      cmd_t        cm;
      acc_cnt++;
      last_acc = cyc + 1;
      w = {4'b0000, program_in, shape_addr_in, reg_addr_in, data_in};
      for (int i = 0; i < 5; i++) begin
        exp_byte_t e;
        e.b = w[39 - 8*i -: 8];
        e.c = last_acc + 10 * C * i;
        exp_q.push_back(e);
      end
      cm.prog = program_in;
      cm.shape = shape_addr_in;
      cm.regad = reg_addr_in;
      cm.data = data_in;
      cmd_q.push_back(cm);
    end
  end

  // UART monitor: finds a start edge, samples mid-bit, and reassembles frames
  // the way the receiving buffer would.
  always begin : uart_mon
    logic       prev_line;
    logic       aborted;
    logic [9:0] bits;
    int         start_c;
    prev_line = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev_line && !serial_output) begin
        start_c = cyc;
        aborted = 1'b0;
        bits = '0;
        for (int k = 1; k <= 9 * C + C / 2; k++) begin
          if (k == 1) bits[0] = serial_output;
          @(negedge clk);
          if (rst) aborted = 1'b1;
          if (k % C == C / 2) bits[k / C] = serial_output;
        end
        if (!aborted) begin
          check("start_bit", 64'(bits[0]), 64'd0);
          check("stop_bit", 64'(bits[9]), 64'd1);
          if (exp_q.size() == 0) begin
            check("exp_q_size", 64'(exp_q.size()), 64'd1);
          end else begin
            exp_byte_t e;
            e = exp_q.pop_front();
            check("byte", 64'(bits[8:1]), 64'(e.b));
            check("start_cyc", 64'(start_c), 64'(e.c));
          end
          rx_word = {rx_word[31:0], bits[8:1]};
          rx_n++;
          if (rx_n == 5) begin
            rx_n = 0;
            if (cmd_q.size() == 0) begin
              check("cmd_q_size", 64'(cmd_q.size()), 64'd1);
            end else begin
              cmd_t cm;
              cm = cmd_q.pop_front();
              check("lb_pad", 64'(rx_word[39:36]), 64'd0);
              check("lb_prog", 64'(rx_word[35]), 64'(cm.prog));
              check("lb_shape", 64'(rx_word[34:24]), 64'(cm.shape));
              check("lb_reg", 64'(rx_word[23:12]), 64'(cm.regad));
              check("lb_data", 64'(rx_word[11:0]), 64'(cm.data));
            end
          end
        end
      end
      prev_line = serial_output;
    end
  end

  task automatic set_fields(input logic p, input logic [10:0] s, input logic [11:0] r,
                            input logic [11:0] d);
    program_in = p;
    shape_addr_in = s;
    reg_addr_in = r;
    data_in = d;
  endtask

  // Returns just after the accept edge (posedge + 1).
  task automatic wait_acc();
    int start_n;
    int t;
    start_n = acc_cnt;
    t = 0;
    while (acc_cnt == start_n && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (acc_cnt == start_n) check("acc_timeout", 64'(acc_cnt - start_n), 64'd1);
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 600) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (done_cnt < target) check("done_timeout", 64'(done_cnt), 64'(target));
  endtask

  task automatic send(input logic p, input logic [10:0] s, input logic [11:0] r,
                      input logic [11:0] d);
    @(posedge clk);
    #1;
    set_fields(p, s, r, d);
    cmd_valid = 1'b1;
    wait_acc();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int t;
    int rst_at;

    // Reset and idle
    repeat (4) begin
      @(negedge clk);
      check("rst_line", 64'(serial_output), 64'd1);
      check("rst_ready", 64'(cmd_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
    end
    rst = 1'b0;
    repeat (100) begin
      @(negedge clk);
      check("idle_line", 64'(serial_output), 64'd1);
      check("idle_ready", 64'(cmd_ready), 64'd1);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_done", 64'(frame_done), 64'd0);
    end

    // Single frame: 09 23 45 67 89
    send(1'b1, 11'h123, 12'h456, 12'h789);
    @(negedge clk);
    check("busy_after_acc", 64'(busy), 64'd1);
    check("ready_after_acc", 64'(cmd_ready), 64'd0);
    wait_done(1);

    // Back-to-back with cmd_valid held; second frame all ones
    @(posedge clk);
    #1;
    set_fields(1'b0, 11'h2AA, 12'h555, 12'hABC);
    cmd_valid = 1'b1;
    wait_acc();
    set_fields(1'b1, 11'h7FF, 12'hFFF, 12'hFFF);
    wait_acc();
    cmd_valid = 1'b0;
    check("b2b_gap", 64'(last_acc - last_done), 64'd1);
    wait_done(3);

    // Input stability: fields and cmd_valid toggle during the frame
    send(1'b0, 11'h0F0, 12'h3C3, 12'h0A5);
    t = 0;
    while (!frame_done && t < 60 * C) begin
      cmd_valid = 1'($urandom_range(0, 1));
      set_fields(1'($urandom), 11'($urandom), 12'($urandom), 12'($urandom));
      @(posedge clk);
      #1;
      t++;
    end
    cmd_valid = 1'b0;
    check("stab_done_seen", 64'(frame_done), 64'd1);
    check("stab_acc_cnt", 64'(acc_cnt), 64'd4);
    wait_done(4);

    // Reset mid-frame during data of byte 2; all-zero fields keep the line low
    send(1'b0, 11'h000, 12'h000, 12'h000);
    rst_at = last_acc + 22 * C + 2;
    t = 0;
    while (cyc < rst_at && t < 400) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    check("pre_rst_line", 64'(serial_output), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_line", 64'(serial_output), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ready", 64'(cmd_ready), 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12 * C) @(negedge clk);
    exp_q.delete();
    cmd_q.delete();
    rx_n = 0;
    send(1'b1, 11'h5A5, 12'hA5A, 12'h3C3);
    wait_done(5);

    // Loopback-style random commands
    for (int i = 0; i < 3; i++) begin
      send(1'($urandom), 11'($urandom), 12'($urandom), 12'($urandom));
      wait_done(6 + i);
    end

    t = 0;
    while ((exp_q.size() != 0 || cmd_q.size() != 0) && t < 1000) begin
      @(posedge clk);
      t++;
    end
    repeat (5 * C) @(negedge clk);
    check("drain_bytes", 64'(exp_q.size()), 64'd0);
    check("drain_cmds", 64'(cmd_q.size()), 64'd0);
    check("total_acc", 64'(acc_cnt), 64'd9);
    check("total_done", 64'(done_cnt), 64'd8);
    check("end_line", 64'(serial_output), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shape_frame_tx.md
# shape_frame_tx

Serializes one shape-register write command (program flag, shape address, register address, data) into a 5-byte UART frame. This is the exact byte stream the input path's UART receiver consumes. The block sits on the host-emulation and loopback side of the renderer's input subsystem. It lets on-chip sources, such as a test pattern sequencer or a readback path, drive the `uart_buffer` serial input without an external PC.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200 baud). Must be ≥ 2.

Ports:
- `clk` in 1: system clock; sole clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command present on the `*_in` fields.
- `cmd_ready` out 1: block can accept a command. High only in IDLE.
- `program_in` in 1: program flag.
- `shape_addr_in` in 11: shape address.
- `reg_addr_in` in 12: register address.
- `data_in` in 12: register data.
- `serial_output` out 1: UART line, 8N1, idle high.
- `busy` out 1: frame in progress (not IDLE).
- `frame_done` out 1: one-cycle pulse when a frame's final stop bit completes.

## Operation
- Frame word, 40 bits: `{4'b0000, program_in, shape_addr_in, reg_addr_in, data_in}`.
- Byte order: sent as 5 bytes, most-significant byte first.
- Bit order within each byte: LSB first (standard UART).
- Bit framing: each byte is 1 start bit (0), 8 data bits, 1 stop bit (1).
- No idle gap between bytes within a frame.
- Command acceptance:
  - A command is accepted on a rising edge where `cmd_valid && cmd_ready`.
  - All four fields are latched into a 40-bit shift/hold register on that edge.
  - Input changes after acceptance are ignored.
- FSM states:
  - IDLE → START on accept.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → STOP after 8 bits.
  - STOP → START if `byte_cnt < 4`, incrementing `byte_cnt`.
  - STOP → IDLE if `byte_cnt == 4`.
- `cmd_valid` while not ready: ignored and not queued. The source must hold it until `cmd_ready`.
- `serial_output` drive per state:
  - IDLE and STOP: 1.
  - START: 0.
  - DATA: current bit.
- Counter widths:
  - Baud counter: `$clog2(CLKS_PER_BIT)` bits, counting 0..`CLKS_PER_BIT`−1.
  - Bit counter: 3 bits.
  - `byte_cnt`: 3 bits, counting 0..4.
- Reset values (all outputs): `serial_output`=1, `cmd_ready`=1, `busy`=0, `frame_done`=0. All counters are 0.
- Reset mid-frame: the line returns high immediately (asynchronously) and the frame is abandoned. The receiver sees a truncated frame; this is acceptable by design.

## Timing
- Accept edge E0: `serial_output` falls at E0 (registered output, start bit begins the cycle after the handshake cycle).
- Bit length: each bit lasts exactly `CLKS_PER_BIT` cycles.
- Frame length: 50·`CLKS_PER_BIT` cycles.
- Frame end: the last stop bit ends at edge E0+50·`CLKS_PER_BIT`. On that edge:
  - state = IDLE;
  - `frame_done`=1 for one cycle;
  - `busy`=0;
  - `cmd_ready`=1.
- Back-to-back commands: a command held valid is accepted on the edge after `frame_done` rises. This gives exactly one idle (mark) cycle between frames.
- `cmd_ready` is combinational from state (`state == IDLE`). `busy` and `frame_done` are registered.

## Structure
- Package `shape_frame_pkg` holds:
  - `FRAME_BYTES`=5 and `FRAME_BITS`=40;
  - field widths (`SHAPE_ADDR_W`=11, `REG_ADDR_W`=12, `DATA_W`=12);
  - a `pack_frame` function.
  The receiver side uses the same package so the two ends cannot diverge.
- Sub-module `uart_tx_byte`:
  - Handles baud counter, start/data/stop for one byte, with a `start`/`done` handshake.
  - The top holds the frame register, `byte_cnt` and the command handshake.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- Reset and idle:
  - Stimulus: hold `rst` high, then release it.
  - Response: `serial_output`=1, `cmd_ready`=1, `busy`=0 throughout. No activity for 100 cycles with `cmd_valid`=0.
- Single frame:
  - Stimulus: `program_in`=1, `shape_addr_in`=11'h123, `reg_addr_in`=12'h456, `data_in`=12'h789.
  - Response: a UART monitor decodes bytes 0x09, 0x23, 0x45, 0x67, 0x89. `frame_done` pulses exactly once, 200 cycles after accept.
- Back-to-back:
  - Stimulus: two commands with `cmd_valid` held continuously. Second command is all-ones fields.
  - Response: second frame bytes 0x0F, 0xFF, 0xFF, 0xFF, 0xFF, with the second start bit exactly 1 cycle after the first `frame_done`.
- Input stability:
  - Stimulus: toggle all input fields and `cmd_valid` every cycle during a frame.
  - Response: the transmitted bytes match the values latched at accept. No second accept occurs until `cmd_ready`.
- Reset mid-frame:
  - Stimulus: assert `rst` during DATA of byte 2.
  - Response: `serial_output`=1 in the same cycle, with `busy`=0 and `cmd_ready`=1. A new command after release transmits a clean full frame.
- Loopback:
  - Stimulus: connect `serial_output` to `uart_buffer`'s serial input and send 3 random commands.
  - Response: the `uart_buffer` outputs (program, shape address, register address, data) match each sent command.
